// File: rtl/reg_dump_reader_if.sv
// Byte stream from the register dump reader to its sink.
// Master drives data/valid/last; slave answers with ready.
interface reg_dump_reader_if;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       outLast;

    modport master (
        output outData,
        output outValid,
        output outLast,
        input  outReady
    );

    modport slave (
        input  outData,
        input  outValid,
        input  outLast,
        output outReady
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register bank debug port R0..R(NUM_REGS-1) and streams
// each register as an index byte followed by its data bytes, MSB first.
module reg_dump_reader #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_W-1:0]     regSel,
    input  logic [DATA_W-1:0]     regData,
    reg_dump_reader_if.master     stream,
    output logic                  busy,
    output logic                  done
);
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SEND_IDX,
        SEND_DATA,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   snap_q, snap_d;
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;

    assign hs = valid_q && stream.outReady;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SELECT;
                    idx_d   = '0;
                end
            end
            SELECT: begin
                snap_d  = regData;
                cnt_d   = '0;
                state_d = SEND_IDX;
            end
            SEND_IDX: begin
                if (hs) state_d = SEND_DATA;
            end
            SEND_DATA: begin
                if (hs) begin
                    if (cnt_q == CNT_MAX) begin
                        if (idx_q == IDX_MAX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = SELECT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are precomputed from next state so every port is a flop.
    always_comb begin
        valid_d = (state_d == SEND_IDX) || (state_d == SEND_DATA);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        last_d  = (state_d == SEND_DATA) && (idx_d == IDX_MAX)
                  && (cnt_d == CNT_MAX);
        data_d  = 8'h00;
        if (state_d == SEND_IDX) begin
            data_d = 8'(idx_d);
        end else if (state_d == SEND_DATA) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (cnt_d == CNT_W'(NBYTES - 1 - b)) begin
                    data_d = snap_d[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign regSel          = idx_q;
    assign stream.outData  = data_q;
    assign stream.outValid = valid_q;
    assign stream.outLast  = last_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: bank model plus expected byte queue
// built from bank contents at start, randomized sink backpressure.
module tb_reg_dump_reader;
    localparam int NREG  = 16;
    localparam int TOTAL = NREG * 5;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  regSel;
    logic [31:0] regData;
    logic        busy;
    logic        done;
    logic [31:0] bank [NREG];

    int n_tests;
    int n_fail;

    reg_dump_reader_if s ();

    reg_dump_reader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .regSel  (regSel),
        .regData (regData),
        .stream  (s.master),
        .busy    (busy),
        .done    (done)
    );

    assign regData = bank[regSel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // mode: 0 ready, 1 toggle, 2 random, 3 stall 50 on first byte
    task automatic dump(input int mode, input bit mutate,
                        input int abort_at);
        logic [7:0] exp_q [$];
        int   got;
        int   stall;
        int   last_c;
        bit   prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        bit   mutated;
        bit   fin;
        bit   rdy;
        int   nd;
        int   nv;
        got = 0; stall = 0; last_c = -1;
        prev_stall = 0; prev_data = 0; prev_last = 0;
        mutated = 0; fin = 0;
        for (int r = 0; r < NREG; r++) begin
            exp_q.push_back(8'(r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(bank[r][b*8 +: 8]);
        end
        @(negedge clk);
        start = 1'b1;
        s.outReady = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 3000 && !fin; c++) begin
            @(negedge clk);
            start = mutate ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (c == 1) begin
                chk("busy_lat", busy, 1);
                chk("valid_lat", s.outValid, 0);
            end
            if (c == 2) chk("first_valid", s.outValid, 1);
            if (prev_stall) begin
                chk("hold_valid", s.outValid, 1);
                chk("hold_data", s.outData, prev_data);
                chk("hold_last", s.outLast, prev_last);
            end
            if (done) begin
                start = 1'b0;
                chk("done_after_last", c, last_c + 1);
                chk("bytes_at_done", got, TOTAL);
                chk("busy_at_done", busy, 1);
                chk("valid_at_done", s.outValid, 0);
                if (mode == 0) chk("done_latency", c, 97);
                fin = 1;
            end else if (abort_at >= 0 && got == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_valid", s.outValid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_regsel", regSel, 0);
                chk("abort_done", done, 0);
                chk("abort_data", s.outData, 0);
                reset = 1'b0;
                nd = 0; nv = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    nd += int'(done);
                    nv += int'(s.outValid);
                end
                chk("abort_no_done", nd, 0);
                chk("abort_no_valid", nv, 0);
                return;
            end else begin
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = c[0];
                    2: rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = !(s.outValid && got == 0 && stall < 50);
                endcase
                s.outReady = rdy;
                if (mode == 3 && s.outValid && !rdy) begin
                    stall++;
                    if (stall == 50) chk("stall_data", s.outData, 8'h00);
                end
                if (s.outValid && rdy) begin
                    chk("byte", s.outData, (got < TOTAL) ? exp_q[got] : 8'hxx);
                    chk("last", s.outLast, got == TOTAL - 1);
                    got++;
                    last_c = c;
                end
                prev_stall = s.outValid && !rdy;
                prev_data  = s.outData;
                prev_last  = s.outLast;
                if (mutate && !mutated && got == 17) begin
                    bank[3] = ~bank[3];
                    mutated = 1;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        start = 1'b0;
        s.outReady = 1'b1;
        nd = 0; nv = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            nd += int'(done);
            nv += int'(s.outValid);
        end
        chk("post_done", nd, 0);
        chk("post_valid", nv, 0);
        chk("post_busy", busy, 0);
        chk("post_regsel", regSel, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        start = 1'b0;
        s.outReady = 1'b0;
        for (int r = 0; r < NREG; r++) bank[r] = 32'(r);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", s.outValid, 0);
        chk("rst_data", s.outData, 0);
        chk("rst_last", s.outLast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_regsel", regSel, 0);
        reset = 1'b0;

        dump(0, 0, -1);
        dump(1, 0, -1);
        bank[5] = 32'hDEADBEEF;
        dump(0, 0, -1);
        dump(2, 1, -1);
        dump(0, 0, 20);
        dump(0, 0, -1);
        dump(3, 0, -1);
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < NREG; r++) bank[r] = $urandom;
            dump(2, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
